// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide controller: restoring divider with RISC-V sign and
// special-case handling, pipeline stall generation and a one-cycle done pulse.
module div_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]   cnt;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] b_abs_q;
    logic            a_neg_q;
    logic            b_neg_q;
    logic            rem_sel_q;

    // Request decode: signs only matter for signed ops
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            b_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            accept;

    always_comb begin
        is_signed   = ~op[0];
        a_neg       = is_signed & a[XLEN-1];
        b_neg       = is_signed & b[XLEN-1];
        a_abs       = a_neg ? -a : a;
        b_abs       = b_neg ? -b : b;
        b_zero      = (b == '0);
        ovf         = is_signed && (a == MIN_NEG) && (b == ALL_ONES);
        special     = b_zero | ovf;
        if (b_zero) begin
            special_res = op[1] ? a : ALL_ONES;
        end else begin
            special_res = op[1] ? '0 : MIN_NEG;
        end
        accept      = (state == IDLE) && start && !flush;
    end

    // One restoring step: shift {rem,quo} left, trial-subtract |b|
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            fits;

    always_comb begin
        shifted = {rem[XLEN-1:0], quo[XLEN-1]};
        diff    = shifted - {1'b0, b_abs_q};
        fits    = ~diff[XLEN];
    end

    // Final sign correction and quotient/remainder select
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        q_fix   = (a_neg_q ^ b_neg_q) ? -quo : quo;
        r_fix   = XLEN'(a_neg_q ? -rem : rem);
        fix_res = rem_sel_q ? r_fix : q_fix;
    end

    // State register with registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= (next_state == DONE);
        end
    end

    // Next-state and stall; flush only reaches stall while IDLE
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = start & ~flush;
                if (start && !flush) begin
                    next_state = special ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush) begin
                    next_state = IDLE;
                end else if (cnt == CNT_LAST) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                stall      = 1'b1;
                next_state = flush ? IDLE : DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            b_abs_q   <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt       <= '0;
                        rem       <= '0;
                        quo       <= a_abs;
                        b_abs_q   <= b_abs;
                        a_neg_q   <= a_neg;
                        b_neg_q   <= b_neg;
                        rem_sel_q <= op[1];
                        if (special) begin
                            result <= special_res;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    rem <= fits ? diff : shifted;
                    quo <= {quo[XLEN-2:0], fits};
                end
                FIX: begin
                    if (!flush) begin
                        result <= fix_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: unsigned/signed results,
// special cases, latency and stall length, flush, async reset, back-to-back.
module tb_div_sequencer;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            flush = 1'b0;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Issue one request from IDLE and wait (bounded) for done
    task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                          output logic [XLEN-1:0] res, output int lat, output int stalls);
        @(negedge clk);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        #1;
        stalls = stall ? 1 : 0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (done) break;
            if (stall) stalls++;
        end
        res = result;
    endtask

    task automatic test_reset();
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [XLEN-1:0] r; int lat; int st;
        run_op(OP_DIVU, 32'd100, 32'd7, r, lat, st);
        total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_100_7 got=%h exp=%h", r, 32'd14); end
        total++; if (lat != 34) begin bad++; $display("FAIL divu_latency got=%0d exp=34", lat); end
        total++; if (st != 34) begin bad++; $display("FAIL divu_stall_cycles got=%0d exp=34", st); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_in_done got=%b exp=0", stall); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", done); end
        total++; if (result !== 32'd14) begin bad++; $display("FAIL result_held got=%h exp=%h", result, 32'd14); end
        run_op(OP_REMU, 32'd100, 32'd7, r, lat, st);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_100_7 got=%h exp=%h", r, 32'd2); end
        run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, r, lat, st);
        total++; if (r !== 32'h7FFF_FFFC) begin bad++; $display("FAIL divu_big got=%h exp=7ffffffc", r); end
    endtask

    task automatic test_signed();
        logic [XLEN-1:0] r; int lat; int st;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, lat, st);
        total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_m7_2 got=%h exp=fffffffd", r); end
        total++; if (lat != 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", lat); end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, r, lat, st);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_m7_2 got=%h exp=ffffffff", r); end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, r, lat, st);
        total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_7_m2 got=%h exp=fffffffd", r); end
        run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, r, lat, st);
        total++; if (r !== 32'd1) begin bad++; $display("FAIL rem_7_m2 got=%h exp=1", r); end
    endtask

    task automatic test_div_by_zero();
        logic [XLEN-1:0] r; int lat; int st;
        run_op(OP_DIV, 32'd5, 32'd0, r, lat, st);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_by0 got=%h exp=ffffffff", r); end
        total++; if (lat != 1) begin bad++; $display("FAIL div_by0_latency got=%0d exp=1", lat); end
        run_op(OP_REMU, 32'h1234, 32'd0, r, lat, st);
        total++; if (r !== 32'h1234) begin bad++; $display("FAIL remu_by0 got=%h exp=1234", r); end
        run_op(OP_REM, 32'hFFFF_FFFB, 32'd0, r, lat, st);
        total++; if (r !== 32'hFFFF_FFFB) begin bad++; $display("FAIL rem_by0_neg got=%h exp=fffffffb", r); end
    endtask

    task automatic test_overflow();
        logic [XLEN-1:0] r; int lat; int st;
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, st);
        total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf got=%h exp=80000000", r); end
        total++; if (lat != 1) begin bad++; $display("FAIL div_ovf_latency got=%0d exp=1", lat); end
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, st);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL rem_ovf got=%h exp=0", r); end
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, st);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL divu_no_ovf got=%h exp=0", r); end
        total++; if (lat != 34) begin bad++; $display("FAIL divu_no_ovf_latency got=%0d exp=34", lat); end
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] r; int lat; int st; int seen;
        logic [XLEN-1:0] prev;
        @(negedge clk); @(negedge clk);
        prev = result;
        op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1; flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b exp=0", stall); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
        flush = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_calc_stall got=%b exp=1", stall); end
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
        total++; if (result !== prev) begin bad++; $display("FAIL flush_result got=%h exp=%h", result, prev); end
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        run_op(OP_DIVU, 32'd9, 32'd3, r, lat, st);
        total++; if (r !== 32'd3) begin bad++; $display("FAIL after_flush got=%h exp=3", r); end
        total++; if (lat != 34) begin bad++; $display("FAIL after_flush_latency got=%0d exp=34", lat); end
    endtask

    task automatic test_async_reset();
        logic [XLEN-1:0] r; int lat; int st;
        @(negedge clk); @(negedge clk);
        op = OP_DIV; a = 32'd100; b = 32'hFFFF_FFF9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        #1;
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b exp=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL arst_result got=%h exp=0", result); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL arst_stall got=%b exp=0", stall); end
        @(negedge clk);
        rst = 1'b1;
        run_op(OP_REMU, 32'd17, 32'd5, r, lat, st);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_17_5 got=%h exp=2", r); end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] r; int lat; int st;
        run_op(OP_DIVU, 32'd100, 32'd7, r, lat, st);
        op = OP_DIVU; a = 32'd50; b = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_in_done_busy got=%b exp=0", busy); end
        total++; if (result !== 32'd14) begin bad++; $display("FAIL start_in_done_result got=%h exp=%h", result, 32'd14); end
        run_op(OP_DIVU, 32'd50, 32'd5, r, lat, st);
        total++; if (r !== 32'd10) begin bad++; $display("FAIL b2b_divu got=%h exp=%h", r, 32'd10); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
